// File: rtl/pe_mac_stream.sv
// Streaming multiply-accumulate PE with valid/ready on both sides and registered systolic operand forwarding.
// Define PE_SAT_EN to saturate the narrowed result and flag ovf; otherwise the result wraps and ovf is 0.
module pe_mac_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+5,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH,
  parameter int KLEN_MAX   = 32,
  parameter int CNT_WIDTH  = $clog2(KLEN_MAX+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [CNT_WIDTH-1:0]  klen,
  input  logic                  is_signed,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic                  fwd_valid,
  output logic [DATA_WIDTH-1:0] data_fwd,
  output logic [DATA_WIDTH-1:0] weight_fwd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  ovf
);

  typedef enum logic [0:0] {S_IDLE, S_ACC} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  klen_q, klen_d;
  logic                  signed_q, signed_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  data_out_q, data_out_d;
  logic                  ovf_q, ovf_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [DATA_WIDTH-1:0] data_fwd_q, data_fwd_d;
  logic [DATA_WIDTH-1:0] weight_fwd_q, weight_fwd_d;

  logic                    beat;
  logic                    mode_eff;
  logic                    is_last;
  logic [CNT_WIDTH-1:0]    klen_eff;
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [2*DATA_WIDTH-1:0] prod_u;
  logic [ACC_WIDTH-1:0]    prod_ext;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic [OUT_WIDTH-1:0]    res_val;
  logic                    res_ovf;

  assign in_ready   = !out_valid_q || out_ready;
  assign beat       = in_valid && in_ready;
  assign fwd_valid  = fwd_valid_q;
  assign data_fwd   = data_fwd_q;
  assign weight_fwd = weight_fwd_q;
  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign ovf        = ovf_q;

  // Mode and length come from the ports on the first beat, from the latched copies afterwards.
  assign mode_eff = (state_q == S_IDLE) ? is_signed : signed_q;

  always_comb begin
    klen_eff = klen;
    if (klen == '0)
      klen_eff = CNT_WIDTH'(1);
    else if (klen > CNT_WIDTH'(KLEN_MAX))
      klen_eff = CNT_WIDTH'(KLEN_MAX);
  end

  assign is_last = (state_q == S_IDLE) ? (klen_eff == CNT_WIDTH'(1))
                                       : (cnt_q == klen_q - CNT_WIDTH'(1));

  assign prod_s = $signed({{DATA_WIDTH{data_in[DATA_WIDTH-1]}}, data_in})
                * $signed({{DATA_WIDTH{weight_in[DATA_WIDTH-1]}}, weight_in});
  assign prod_u = {{DATA_WIDTH{1'b0}}, data_in} * {{DATA_WIDTH{1'b0}}, weight_in};

  assign prod_ext = mode_eff
    ? {{(ACC_WIDTH-2*DATA_WIDTH){prod_s[2*DATA_WIDTH-1]}}, prod_s}
    : {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod_u};

  assign acc_sum = ((state_q == S_IDLE) ? '0 : acc_q) + prod_ext;

`ifdef PE_SAT_EN
  always_comb begin
    res_val = acc_sum[OUT_WIDTH-1:0];
    res_ovf = 1'b0;
    if (mode_eff) begin
      if (acc_sum[ACC_WIDTH-1:OUT_WIDTH-1] != '0 && acc_sum[ACC_WIDTH-1:OUT_WIDTH-1] != '1) begin
        res_ovf = 1'b1;
        res_val = acc_sum[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end else if (acc_sum[ACC_WIDTH-1:OUT_WIDTH] != '0) begin
      res_ovf = 1'b1;
      res_val = '1;
    end
  end
`else
  assign res_val = acc_sum[OUT_WIDTH-1:0];
  assign res_ovf = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    klen_d       = klen_q;
    signed_d     = signed_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    ovf_d        = ovf_q;
    fwd_valid_d  = beat;
    data_fwd_d   = data_fwd_q;
    weight_fwd_d = weight_fwd_q;

    if (beat) begin
      data_fwd_d   = data_in;
      weight_fwd_d = weight_in;
    end

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    // clr discards the accumulation only; forwarding and any pending result are left alone.
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (beat) begin
      acc_d = acc_sum;
      if (state_q == S_IDLE) begin
        klen_d   = klen_eff;
        signed_d = is_signed;
      end
      if (is_last) begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        data_out_d  = res_val;
        ovf_d       = res_ovf;
      end else begin
        state_d = S_ACC;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      klen_q       <= '0;
      signed_q     <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      ovf_q        <= 1'b0;
      fwd_valid_q  <= 1'b0;
      data_fwd_q   <= '0;
      weight_fwd_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      klen_q       <= klen_d;
      signed_q     <= signed_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      ovf_q        <= ovf_d;
      fwd_valid_q  <= fwd_valid_d;
      data_fwd_q   <= data_fwd_d;
      weight_fwd_q <= weight_fwd_d;
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench for pe_mac_stream: constant-vector table, directed corner sequences,
// and randomized traffic against a window-level reference model.
module tb_pe_mac_stream;

  logic        clk = 1'b0;
  logic        rst, clr, is_signed, in_valid, out_ready;
  logic [5:0]  klen;
  logic [7:0]  data_in, weight_in;
  logic        in_ready, fwd_valid, out_valid, ovf;
  logic [7:0]  data_fwd, weight_fwd;
  logic [15:0] data_out;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  pe_mac_stream #(
    .DATA_WIDTH(8), .ACC_WIDTH(21), .OUT_WIDTH(16), .KLEN_MAX(32), .CNT_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .klen(klen), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .weight_in(weight_in),
    .fwd_valid(fwd_valid), .data_fwd(data_fwd), .weight_fwd(weight_fwd),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .ovf(ovf)
  );

  typedef struct { logic [7:0] d; logic [7:0] w; } pair_t;

  // Reference model: the current window as a list of operand pairs plus the visible outputs.
  pair_t       win[$];
  int          m_klen;
  logic        m_sign;
  logic        m_out_valid, m_ovf, m_fwd_valid;
  logic [15:0] m_data;
  logic [7:0]  m_dfwd, m_wfwd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input logic [5:0] k);
    if (k == 0) return 1;
    if (k > 32) return 32;
    return int'(k);
  endfunction

  function automatic void window_result(output logic [15:0] r, output logic o);
    longint sum = 0;
    foreach (win[i])
      sum += m_sign ? longint'($signed(win[i].d)) * longint'($signed(win[i].w))
                    : longint'(win[i].d) * longint'(win[i].w);
    r = sum[15:0];
    o = 1'b0;
`ifdef PE_SAT_EN
    if (m_sign) begin
      if (sum > 32767)       begin r = 16'h7FFF; o = 1'b1; end
      else if (sum < -32768) begin r = 16'h8000; o = 1'b1; end
    end else if (sum > 65535) begin
      r = 16'hFFFF; o = 1'b1;
    end
`endif
  endfunction

  task automatic check_outputs();
    chk("out_valid",  out_valid,  m_out_valid);
    chk("data_out",   data_out,   m_data);
    chk("ovf",        ovf,        m_ovf);
    chk("fwd_valid",  fwd_valid,  m_fwd_valid);
    chk("data_fwd",   data_fwd,   m_dfwd);
    chk("weight_fwd", weight_fwd, m_wfwd);
  endtask

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic [7:0] w,
                       input logic [5:0] k, input logic s, input logic ordy, input logic c);
    logic beat;
    logic [15:0] r;
    logic o;
    rst = 1'b0; in_valid = iv; data_in = d; weight_in = w;
    klen = k; is_signed = s; out_ready = ordy; clr = c;
    #1;
    chk("in_ready", in_ready, !m_out_valid || ordy);
    beat = iv && (!m_out_valid || ordy);
    @(posedge clk);
    if (m_out_valid && ordy) m_out_valid = 1'b0;
    m_fwd_valid = beat;
    if (beat) begin m_dfwd = d; m_wfwd = w; end
    if (c) win.delete();
    else if (beat) begin
      if (win.size() == 0) begin m_klen = eff_len(k); m_sign = s; end
      win.push_back('{d, w});
      if (win.size() == m_klen) begin
        window_result(r, o);
        m_data = r; m_ovf = o; m_out_valid = 1'b1;
        win.delete();
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; data_in = 8'h5A; weight_in = 8'hA5;
    klen = 6'd1; is_signed = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst in_ready",   in_ready,   1'b1);
    chk("rst fwd_valid",  fwd_valid,  1'b0);
    chk("rst data_fwd",   data_fwd,   8'h00);
    chk("rst weight_fwd", weight_fwd, 8'h00);
    chk("rst out_valid",  out_valid,  1'b0);
    chk("rst data_out",   data_out,   16'h0000);
    chk("rst ovf",        ovf,        1'b0);
    win.delete();
    m_klen = 1; m_sign = 1'b0; m_out_valid = 1'b0; m_ovf = 1'b0; m_fwd_valid = 1'b0;
    m_data = '0; m_dfwd = '0; m_wfwd = '0;
  endtask

  typedef struct {
    logic [5:0]  klen;
    logic        sgn;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  dstep;
    logic [7:0]  w;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{6'd9,  1'b0, 9,  8'd1,   8'd1, 8'd2,   16'd90,   1'b0};
`ifdef PE_SAT_EN
    tbl[1] = '{6'd32, 1'b0, 32, 8'd255, 8'd0, 8'd255, 16'hFFFF, 1'b1};
    tbl[5] = '{6'd32, 1'b1, 32, 8'h80,  8'd0, 8'h7F,  16'h8000, 1'b1};
    tbl[6] = '{6'd2,  1'b1, 2,  8'h80,  8'd0, 8'h80,  16'h7FFF, 1'b1};
`else
    tbl[1] = '{6'd32, 1'b0, 32, 8'd255, 8'd0, 8'd255, 16'hC020, 1'b0};
    tbl[5] = '{6'd32, 1'b1, 32, 8'h80,  8'd0, 8'h7F,  16'h1000, 1'b0};
    tbl[6] = '{6'd2,  1'b1, 2,  8'h80,  8'd0, 8'h80,  16'h8000, 1'b0};
`endif
    tbl[2] = '{6'd0,  1'b0, 1,  8'd7,   8'd0, 8'd6,   16'd42,   1'b0};
    tbl[3] = '{6'd40, 1'b0, 32, 8'd1,   8'd0, 8'd1,   16'd32,   1'b0};
    tbl[4] = '{6'd4,  1'b1, 4,  8'hFE,  8'd1, 8'hFD,  16'd6,    1'b0};
    tbl[7] = '{6'd1,  1'b1, 1,  8'h80,  8'd0, 8'h80,  16'h4000, 1'b0};

    do_reset();

    foreach (tbl[t]) begin
      for (int i = 0; i < tbl[t].n; i++)
        cycle(1'b1, 8'(tbl[t].d0 + 8'(i) * tbl[t].dstep), tbl[t].w, tbl[t].klen, tbl[t].sgn, 1'b1, 1'b0);
      chk($sformatf("tbl%0d out_valid", t), out_valid, 1'b1);
      chk($sformatf("tbl%0d data_out", t), data_out, tbl[t].exp_data);
      chk($sformatf("tbl%0d ovf", t), ovf, tbl[t].exp_ovf);
    end
    cycle(1'b0, 8'd0, 8'd0, 6'd1, 1'b0, 1'b1, 1'b0);

    // Signed window; later beats present a different klen/mode that must be ignored.
    cycle(1'b1, 8'h80, 8'h7F, 6'd3, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'hFF, 8'hFF, 6'd1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'd5,  8'hFD, 6'd9, 1'b0, 1'b1, 1'b0);
    chk("signed data_out", data_out, 16'hC072);
    chk("signed ovf", ovf, 1'b0);

    // Back-to-back single-beat windows.
    cycle(1'b1, 8'd3, 8'd4, 6'd1, 1'b0, 1'b1, 1'b0);
    chk("b2b first", data_out, 16'd12);
    cycle(1'b1, 8'd5, 8'd6, 6'd1, 1'b0, 1'b1, 1'b0);
    chk("b2b second", data_out, 16'd30);
    chk("b2b out_valid", out_valid, 1'b1);

    // Backpressure: result held, input stalled, then drain plus new beat in one cycle.
    cycle(1'b1, 8'd3, 8'd4, 6'd1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'd9, 8'd9, 6'd1, 1'b0, 1'b0, 1'b0);
    chk("bp in_ready", in_ready, 1'b0);
    chk("bp data_out", data_out, 16'd12);
    cycle(1'b1, 8'd9, 8'd9, 6'd1, 1'b0, 1'b1, 1'b0);
    chk("bp drain data_out", data_out, 16'd81);

    // Abort after 4 of 9 beats, then a fresh window of ones.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd2, 8'd2, 6'd9, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 8'hAA, 6'd9, 1'b0, 1'b1, 1'b1);
    chk("clr fwd data", data_fwd, 8'h55);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'd1, 8'd1, 6'd9, 1'b0, 1'b1, 1'b0);
    chk("clr fresh window", data_out, 16'd9);

    // Reset in the middle of a window.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd7, 8'd7, 6'd9, 1'b0, 1'b1, 1'b0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else
        cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 6'($urandom_range(0, 40)),
              1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
